clkgate_ctrl: RTL and testbench
===============================

# clkgate_ctrl

Multi-channel clock-gate controller: a parametrised successor to the single-channel latch-based gate. Each channel owns a glitch-free gated clock with a request/acknowledge handshake and a programmable idle hold-off before the clock is stopped. It sits in the clock subsystem between block-level power-management requests and the gated clock trees of downstream units.

## Interface

Parameters:
- `NCH`, 4: number of independent gated-clock channels (1..32).
- `IDLE_W`, 4: width of the idle hold-off count.

Ports:
- `clk`, input, 1: free-running source clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `req`, input, NCH: per-channel clock request, synchronous to `clk`.
- `idle_cyc`, input, IDLE_W: hold-off length in cycles; sampled only when a channel enters DRAIN.
- `ack`, output, NCH: per-channel "gated clock running" indication, registered.
- `gclk`, output, NCH: per-channel gated clock.
- `any_on`, output, 1: OR of `ack`, registered.
- `test_en`, input, 1: present only with `CLKGATE_CTRL_TEST_EN`.

## Operation

- Per-channel FSM with states OFF, WAKE, ON and DRAIN, and a per-channel IDLE_W-bit down-counter `cnt`.
- `en` = (state != OFF), registered. `gclk[i]` = `clk` AND `en` latched while `clk` is low. This gives glitch-free output with whole pulses only.
- Transitions, evaluated at each rising edge:
  - OFF: `req`=1 → WAKE; otherwise stay.
  - WAKE: → ON unconditionally. `req` is ignored in WAKE; a drop is handled in ON.
  - ON: `req`=1 → stay. `req`=0 with `idle_cyc`=0 → OFF. `req`=0 with `idle_cyc`≠0 → DRAIN, with `cnt` ← `idle_cyc`.
  - DRAIN: `req`=1 → ON, and `cnt` is discarded. `req`=0 with `cnt`=1 → OFF. Otherwise `cnt` ← `cnt`−1.
- `ack[i]`=1 in ON and DRAIN, 0 in OFF and WAKE.
- Channels are fully independent; no arbitration or ordering between them.
- A change to `idle_cyc` while a channel is in DRAIN does not affect that drain.

## Timing

- Reset values: state OFF, `cnt`=0, `en`=0, the latch is cleared asynchronously, `ack`=0, `any_on`=0, `gclk`=0.
- Reset asserted mid-operation: `gclk` is forced low immediately. A truncated high pulse is acceptable only at reset assertion.
- Wake latency, with `req` first sampled high at edge E0:
  - WAKE after E0.
  - First `gclk` rising edge coincides with E1.
  - `ack`=1 after E1.
  - `ack` never precedes the first gated pulse.
- Stop latency, with `req` first sampled low at edge Ek in ON:
  - `gclk` pulses continue through edge Ek+`idle_cyc` inclusive; none after.
  - `ack` falls after edge Ek+`idle_cyc`.
- `req` pulse of 1 cycle from OFF: WAKE → ON → OFF/DRAIN. At least 2 gated pulses, plus `idle_cyc`.
- Re-request during DRAIN: `ack` stays 1 and `gclk` runs with no gap.
- `any_on` lags `ack` by 0 cycles; it is computed from the next-state `ack` and registered together with it.

## Configuration

- `CLKGATE_CTRL_TEST_EN` defined:
  - Adds the `test_en` port.
  - `test_en`=1 forces every latch input to 1, so `gclk`=`clk` on all channels. This is the scan/test bypass.
  - FSMs, `ack` and `any_on` are unaffected by `test_en`.
- `CLKGATE_CTRL_TEST_EN` undefined:
  - No `test_en` port.
  - Gating is controlled by the FSM only.

## Structure

- Package `clkgate_pkg`:
  - FSM state enum (OFF, WAKE, ON, DRAIN), 2-bit encoding.
  - Localparam limits for `NCH`.
- Sub-module `clkgate_cell`:
  - Latch plus AND, with async clear from `rst_n`.
  - Optional `te` input under `CLKGATE_CTRL_TEST_EN`.
  - Instantiated NCH times.
  - Keeps the latch isolated for synthesis/ICG cell mapping.
- Top level holds the per-channel FSM and counters in a generate loop.

## Test plan

- Reset: hold `rst_n`=0 with `req`=all-ones → `gclk`=0, `ack`=0, `any_on`=0. Release → `ack[i]`=1 exactly 2 edges later, first `gclk` pulse at edge 2.
- Stop with `idle_cyc`=3, `req[0]` dropped at Ek → 3 more `gclk[0]` pulses after Ek (edges Ek+1..Ek+3), none at Ek+4, `ack[0]` falls after Ek+3.
- `idle_cyc`=0 → last pulse at Ek, `ack` falls after Ek. `idle_cyc`=15 → 15 extra pulses.
- Re-request in DRAIN (`idle_cyc`=5, `req` low 2 cycles then high) → no missing `gclk` pulse, `ack` continuously 1.
- Independence, NCH=4 with staggered random `req` → each channel matches the reference model; `any_on` = OR(`ack`). Assert async reset while `clk` is high → `gclk` low within the same phase, FSMs OFF.
- With `CLKGATE_CTRL_TEST_EN`, `test_en`=1 and `req`=0 → `gclk`=`clk` on all channels, `ack`=0.

Source files
------------

// File: rtl/clkgate_pkg.sv
// Shared types and limits for the multi-channel clock-gate controller.
package clkgate_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_WAKE  = 2'd1,
        ST_ON    = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam int NCH_MIN = 1;
    localparam int NCH_MAX = 32;

    // The gated clock is acknowledged only once the channel is past its wake cycle.
    function automatic logic is_acked(state_t s);
        return (s == ST_ON) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/clkgate_cell.sv
// Latch-plus-AND clock gate with async clear; kept standalone so it maps onto an ICG cell.
// Optional scan bypass input te exists only when CLKGATE_CTRL_TEST_EN is defined.
module clkgate_cell (
    input  logic clk,
    input  logic rst_n,
`ifdef CLKGATE_CTRL_TEST_EN
    input  logic te,
`endif
    input  logic en,
    output logic gclk
);

    logic lat_d;
    logic en_lat;

`ifdef CLKGATE_CTRL_TEST_EN
    assign lat_d = en | te;
`else
    assign lat_d = en;
`endif

    // Transparent while clk is low, so the enable can only change between pulses.
    always_latch begin
        if (!rst_n) begin
            en_lat = 1'b0;
        end else if (!clk) begin
            en_lat = lat_d;
        end
    end

    assign gclk = clk & en_lat;

endmodule

// File: rtl/clkgate_ctrl.sv
// Multi-channel clock-gate controller: per-channel OFF/WAKE/ON/DRAIN FSM with idle hold-off.
// Optional scan bypass port test_en is present only when CLKGATE_CTRL_TEST_EN is defined.
module clkgate_ctrl
    import clkgate_pkg::*;
#(
    parameter int NCH    = 4,
    parameter int IDLE_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef CLKGATE_CTRL_TEST_EN
    input  logic              test_en,
`endif
    input  logic [NCH-1:0]    req,
    input  logic [IDLE_W-1:0] idle_cyc,
    output logic [NCH-1:0]    ack,
    output logic [NCH-1:0]    gclk,
    output logic              any_on
);

    logic [NCH-1:0] en;
    logic [NCH-1:0] en_nxt;
    logic [NCH-1:0] ack_nxt;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        state_t            state;
        state_t            state_nxt;
        logic [IDLE_W-1:0] cnt;
        logic [IDLE_W-1:0] cnt_nxt;

        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            case (state)
                ST_OFF: begin
                    if (req[i]) state_nxt = ST_WAKE;
                end
                ST_WAKE: begin
                    state_nxt = ST_ON;
                end
                ST_ON: begin
                    if (!req[i]) begin
                        if (idle_cyc == '0) begin
                            state_nxt = ST_OFF;
                        end else begin
                            state_nxt = ST_DRAIN;
                            cnt_nxt   = idle_cyc;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (req[i]) begin
                        state_nxt = ST_ON;
                        cnt_nxt   = '0;
                    end else if (cnt == IDLE_W'(1)) begin
                        state_nxt = ST_OFF;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_OFF;
                    cnt_nxt   = '0;
                end
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state <= ST_OFF;
                cnt   <= '0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
            end
        end

        assign en_nxt[i]  = (state_nxt != ST_OFF);
        assign ack_nxt[i] = is_acked(state_nxt);

        clkgate_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
`ifdef CLKGATE_CTRL_TEST_EN
            .te    (test_en),
`endif
            .en    (en[i]),
            .gclk  (gclk[i])
        );
    end

    // any_on is derived from next-state ack so it never lags the per-channel acks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en     <= '0;
            ack    <= '0;
            any_on <= 1'b0;
        end else begin
            en     <= en_nxt;
            ack    <= ack_nxt;
            any_on <= |ack_nxt;
        end
    end

endmodule

// File: tb/tb_clkgate_ctrl.sv
// Scoreboard bench for clkgate_ctrl: edge-level reference model feeds an expected queue.
module tb_clkgate_ctrl;

    localparam int NCH    = 4;
    localparam int IDLE_W = 4;
    localparam int W      = 2 * NCH + 1;

    logic              clk;
    logic              rst_n;
    logic [NCH-1:0]    req;
    logic [IDLE_W-1:0] idle_cyc;
    logic [NCH-1:0]    ack;
    logic [NCH-1:0]    gclk;
    logic              any_on;
`ifdef CLKGATE_CTRL_TEST_EN
    logic              test_en;
`endif

    clkgate_ctrl #(.NCH(NCH), .IDLE_W(IDLE_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef CLKGATE_CTRL_TEST_EN
        .test_en  (test_en),
`endif
        .req      (req),
        .idle_cyc (idle_cyc),
        .ack      (ack),
        .gclk     (gclk),
        .any_on   (any_on)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic mon_en = 1'b0;
    logic [W-1:0] exp_q[$];

    // Reference model: a channel is "alive" while its clock runs; "waking" marks the
    // first edge after a request; "left" counts hold-off edges remaining (-1 = not draining).
    int m_alive[NCH];
    int m_waking[NCH];
    int m_left[NCH];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_alive[i]  = 0;
            m_waking[i] = 0;
            m_left[i]   = -1;
        end
    endtask

    // Predict one rising edge: pulses seen at the edge and ack/any_on just after it.
    task automatic model_edge(input logic [NCH-1:0] r, input int idle, output logic [W-1:0] e);
        logic [NCH-1:0] pulse;
        logic [NCH-1:0] ak;
        for (int i = 0; i < NCH; i++) begin
            pulse[i] = (m_alive[i] != 0);
            if (m_alive[i] == 0) begin
                if (r[i]) begin
                    m_alive[i]  = 1;
                    m_waking[i] = 1;
                end
            end else if (m_waking[i] != 0) begin
                m_waking[i] = 0;
            end else if (r[i]) begin
                m_left[i] = -1;
            end else begin
                if (m_left[i] < 0) m_left[i] = idle;
                if (m_left[i] == 0) begin
                    m_alive[i] = 0;
                    m_left[i]  = -1;
                end else begin
                    m_left[i] = m_left[i] - 1;
                end
            end
            ak[i] = (m_alive[i] != 0) && (m_waking[i] == 0);
        end
        e = {|ak, ak, pulse};
    endtask

    // Driver: called at a falling edge; drives inputs, pushes the prediction, waits one cycle.
    task automatic step(input logic [NCH-1:0] r, input int idle);
        logic [W-1:0] e;
        req      = r;
        idle_cyc = IDLE_W'(idle);
        model_edge(r, idle, e);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: compares at each rising edge and verifies gclk stays low in the low phase.
    always @(posedge clk) begin
        #1;
        if (mon_en && exp_q.size() > 0) begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            check("edge_outputs", {any_on, ack, gclk}, e);
        end
    end

    always @(negedge clk) begin
        #1;
        if (mon_en) check("gclk_low_phase", W'(gclk), W'(0));
    end

    logic [NCH-1:0] rq;

    initial begin
        rst_n    = 1'b0;
        req      = '1;
        idle_cyc = '0;
`ifdef CLKGATE_CTRL_TEST_EN
        test_en  = 1'b0;
`endif
        model_reset();
        repeat (3) @(posedge clk);
        #1 check("reset_hold", {any_on, ack, gclk}, W'(0));
        @(negedge clk);
        #1 check("reset_hold_low", {any_on, ack, gclk}, W'(0));

        // Release with all channels requesting: ack at edge 2, first pulse at edge 2.
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (4) step('1, 3);

        // Drop req[0] with hold-off 3, then 0, then 15.
        repeat (6) step(4'b1110, 3);
        repeat (3) step(4'b1111, 3);
        repeat (3) step(4'b1110, 0);
        repeat (3) step(4'b1111, 0);
        repeat (18) step(4'b1110, 15);
        repeat (3) step(4'b1111, 15);

        // Re-request during drain: ack must stay high, no missing pulse.
        repeat (2) step(4'b1110, 5);
        repeat (4) step(4'b1111, 5);

        // Staggered random requests with idle_cyc changing underneath drains.
        rq = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NCH; i++)
                if ($urandom_range(0, 5) == 0) rq[i] = ~rq[i];
            step(rq, (c % 3 == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 4)));
        end

        // Async reset asserted while clk is high with channels running.
        repeat (4) step('1, 2);
        mon_en = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset_mid_high", {any_on, ack, gclk}, W'(0));
        check("scoreboard_drained", W'(exp_q.size()), W'(0));
        exp_q.delete();
        model_reset();
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        rq = '0;
        for (int c = 0; c < 100; c++) begin
            for (int i = 0; i < NCH; i++)
                if ($urandom_range(0, 3) == 0) rq[i] = ~rq[i];
            step(rq, int'($urandom_range(0, 6)));
        end
        repeat (20) step('0, 0);

`ifdef CLKGATE_CTRL_TEST_EN
        // Scan bypass: gclk follows clk on every channel while FSMs stay OFF.
        mon_en  = 1'b0;
        test_en = 1'b1;
        req     = '0;
        @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1 check("test_en_high", {any_on, ack, gclk}, {1'b0, {NCH{1'b0}}, {NCH{1'b1}}});
            @(negedge clk);
            #1 check("test_en_low", {any_on, ack, gclk}, W'(0));
        end
        test_en = 1'b0;
`endif

        @(posedge clk);
        #2 check("scoreboard_empty", W'(exp_q.size()), W'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
